// File: rtl/reverb_template_nios2_debug_scan_master.sv
// Virtual-JTAG scan master: walks the debug slave through UIR/CDR/SDR/UDR/RTI
// on a divided scan clock and hands back the captured data register.
module reverb_template_nios2_debug_scan_master #(
  parameter int TCK_DIV = 2,
  parameter int DR_LEN  = 38
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_ir,
  input  logic [DR_LEN-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DR_LEN-1:0] rsp_data,
  output logic              vji_tck,
  output logic              vji_tdi,
  input  logic              vji_tdo,
  output logic [1:0]        vji_ir_in,
  output logic              vji_uir,
  output logic              vji_cdr,
  output logic              vji_sdr,
  output logic              vji_udr,
  output logic              vji_rti
);

  localparam int CW = 9;
  localparam int BW = $clog2(DR_LEN + 1);
  localparam logic [CW-1:0] HALF     = CW'(TCK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * TCK_DIV - 1);
  localparam logic [CW-1:0] RISE_AT  = CW'(TCK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DR_LEN - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UIR  = 3'd1,
    CDR  = 3'd2,
    SDR  = 3'd3,
    UDR  = 3'd4,
    RTI  = 3'd5,
    RESP = 3'd6
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic              period_done;
  logic [BW-1:0]     bit_q;
  logic              ready_q;
  logic              rsp_valid_q;
  logic [DR_LEN-1:0] rx_q;
  logic [DR_LEN-1:0] tx_q;
  logic              tck_q;
  logic              tdi_q;
  logic [1:0]        ir_q;
  logic              uir_q, cdr_q, sdr_q, udr_q, rti_q;

  assign cnt_d       = cnt_q + {{(CW-1){1'b0}}, 1'b1};
  assign period_done = (cnt_q == CNT_LAST);

  // ready_q is already 1 while reset is held, so gate it to keep the port low then
  assign cmd_ready = ready_q & ~reset;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rx_q;
  assign vji_tck   = tck_q;
  assign vji_tdi   = tdi_q;
  assign vji_ir_in = ir_q;
  assign vji_uir   = uir_q;
  assign vji_cdr   = cdr_q;
  assign vji_sdr   = sdr_q;
  assign vji_udr   = udr_q;
  assign vji_rti   = rti_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rx_q        <= '0;
      tx_q        <= '0;
      tck_q       <= 1'b0;
      tdi_q       <= 1'b0;
      ir_q        <= 2'b00;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      rti_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid && ready_q) begin
            state_q <= UIR;
            ready_q <= 1'b0;
            tx_q    <= cmd_data;
            ir_q    <= cmd_ir;
            uir_q   <= 1'b1;
            cnt_q   <= '0;
            tck_q   <= 1'b0;
          end
        end
        UIR, CDR, SDR, UDR, RTI: begin
          if (period_done) begin
            // every period closes on a low tck; tdi only moves here
            cnt_q <= '0;
            tck_q <= 1'b0;
            case (state_q)
              UIR: begin
                state_q <= CDR;
                uir_q   <= 1'b0;
                cdr_q   <= 1'b1;
              end
              CDR: begin
                state_q <= SDR;
                cdr_q   <= 1'b0;
                sdr_q   <= 1'b1;
                bit_q   <= '0;
                tdi_q   <= tx_q[0];
                tx_q    <= {1'b0, tx_q[DR_LEN-1:1]};
              end
              SDR: begin
                if (bit_q == BIT_LAST) begin
                  state_q <= UDR;
                  sdr_q   <= 1'b0;
                  udr_q   <= 1'b1;
                  bit_q   <= '0;
                  tdi_q   <= 1'b0;
                end else begin
                  bit_q <= bit_q + {{(BW-1){1'b0}}, 1'b1};
                  tdi_q <= tx_q[0];
                  tx_q  <= {1'b0, tx_q[DR_LEN-1:1]};
                end
              end
              UDR: begin
                state_q <= RTI;
                udr_q   <= 1'b0;
                rti_q   <= 1'b1;
              end
              RTI: begin
                state_q     <= RESP;
                rti_q       <= 1'b0;
                rsp_valid_q <= 1'b1;
              end
              default: state_q <= IDLE;
            endcase
          end else begin
            cnt_q <= cnt_d;
            tck_q <= (cnt_d >= HALF);
            if (state_q == SDR && cnt_q == RISE_AT) begin
              rx_q <= {vji_tdo, rx_q[DR_LEN-1:1]};
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reverb_template_nios2_debug_scan_master.sv
// Directed bench for the scan master: a default instance with tdo looped or
// tied high, and a TCK_DIV=1 instance for the fast-clock timing.
module tb_reverb_template_nios2_debug_scan_master;

  localparam int DR = 38;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [1:0]    cmd_ir, vji_ir_in;
  logic [DR-1:0] cmd_data, rsp_data;
  logic          vji_tck, vji_tdi, vji_tdo;
  logic          vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  logic          tdo_one;

  logic          c1_valid, c1_ready, c1_rvalid, c1_rready;
  logic [1:0]    c1_ir, c1_ir_in;
  logic [DR-1:0] c1_data, c1_rdata;
  logic          c1_tck, c1_tdi, c1_tdo;
  logic          c1_uir, c1_cdr, c1_sdr, c1_udr, c1_rti;

  assign vji_tdo = tdo_one ? 1'b1 : vji_tdi;
  assign c1_tdo  = c1_tdi;

  reverb_template_nios2_debug_scan_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
  );

  reverb_template_nios2_debug_scan_master #(.TCK_DIV(1), .DR_LEN(DR)) dut1 (
    .clk(clk), .reset(reset),
    .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_ir(c1_ir), .cmd_data(c1_data),
    .rsp_valid(c1_rvalid), .rsp_ready(c1_rready), .rsp_data(c1_rdata),
    .vji_tck(c1_tck), .vji_tdi(c1_tdi), .vji_tdo(c1_tdo), .vji_ir_in(c1_ir_in),
    .vji_uir(c1_uir), .vji_cdr(c1_cdr), .vji_sdr(c1_sdr), .vji_udr(c1_udr), .vji_rti(c1_rti)
  );

  typedef struct packed {
    logic [1:0]    ir;
    logic [DR-1:0] data;
    logic          one;
    logic [DR-1:0] exp;
  } vec_t;

  vec_t vecs [6];
  int   checks = 0;
  int   errors = 0;

  int   sdr_rises, tdi_out_err, tck_idle_err, overlap_err, tdi_chg_err, tdi_seen_one;
  int   scnt [5];
  int   c1_tog_err;
  int   c1cnt [5];
  logic prev_tck = 1'b0, prev_tdi = 1'b0, prev_c1_tck = 1'b0, prev_c1_act = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    sdr_rises = 0; tdi_out_err = 0; tck_idle_err = 0; overlap_err = 0;
    tdi_chg_err = 0; tdi_seen_one = 0; c1_tog_err = 0;
    for (int i = 0; i < 5; i++) begin
      scnt[i] = 0;
      c1cnt[i] = 0;
    end
  endtask

  // One clock: advance past the rising edge, then observe both instances at the falling edge
  task automatic step();
    logic [4:0] s, s1;
    logic       act1;
    @(posedge clk);
    @(negedge clk);
    s  = {vji_rti, vji_udr, vji_sdr, vji_cdr, vji_uir};
    s1 = {c1_rti, c1_udr, c1_sdr, c1_cdr, c1_uir};
    if (vji_tck && !prev_tck && vji_sdr) sdr_rises++;
    if (vji_tdi && !vji_sdr) tdi_out_err++;
    if (vji_tck && (cmd_ready || rsp_valid)) tck_idle_err++;
    if ($countones(s) > 1) overlap_err++;
    if ((vji_tdi != prev_tdi) && !(prev_tck && !vji_tck)) tdi_chg_err++;
    if (vji_tdi) tdi_seen_one++;
    act1 = |s1;
    if (act1 && prev_c1_act && (c1_tck == prev_c1_tck)) c1_tog_err++;
    for (int i = 0; i < 5; i++) begin
      scnt[i]  += int'(s[i]);
      c1cnt[i] += int'(s1[i]);
    end
    prev_tck = vji_tck; prev_tdi = vji_tdi;
    prev_c1_tck = c1_tck; prev_c1_act = act1;
  endtask

  task automatic run_cmd(input string tag, input vec_t v);
    int n;
    tdo_one = v.one;
    chk({tag, "_ready"}, cmd_ready, 1);
    cmd_ir = v.ir; cmd_data = v.data; cmd_valid = 1'b1;
    clr_mon();
    step(); n = 1;
    cmd_valid = 1'b0;
    chk({tag, "_ir_at_uir"}, vji_ir_in, v.ir);
    chk({tag, "_uir_entry"}, vji_uir, 1);
    while (!rsp_valid && n < 400) begin step(); n++; end
    chk({tag, "_latency"}, n, 169);
    chk({tag, "_data"}, rsp_data, v.exp);
    chk({tag, "_sdr_rises"}, sdr_rises, 38);
    chk({tag, "_uir_cyc"}, scnt[0], 4);
    chk({tag, "_cdr_cyc"}, scnt[1], 4);
    chk({tag, "_sdr_cyc"}, scnt[2], 152);
    chk({tag, "_udr_cyc"}, scnt[3], 4);
    chk({tag, "_rti_cyc"}, scnt[4], 4);
    chk({tag, "_tdi_outside"}, tdi_out_err, 0);
    chk({tag, "_tck_idle"}, tck_idle_err, 0);
    chk({tag, "_overlap"}, overlap_err, 0);
    chk({tag, "_tdi_timing"}, tdi_chg_err, 0);
    if (v.data == '0) chk({tag, "_tdi_zero"}, tdi_seen_one, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, rsp_valid, 0);
    chk({tag, "_ready_back"}, cmd_ready, 1);
  endtask

  initial begin
    int n, bad;
    vecs[0] = '{2'b01, 38'h2A_5555_AAAA, 1'b0, 38'h2A_5555_AAAA};
    vecs[1] = '{2'b10, 38'h00_0000_0000, 1'b1, 38'h3F_FFFF_FFFF};
    vecs[2] = '{2'b11, 38'h3F_FFFF_FFFF, 1'b0, 38'h3F_FFFF_FFFF};
    vecs[3] = '{2'b00, 38'h00_0000_0001, 1'b0, 38'h00_0000_0001};
    vecs[4] = '{2'b01, 38'h20_0000_0000, 1'b1, 38'h3F_FFFF_FFFF};
    vecs[5] = '{2'b10, 38'h15_AAAA_5555, 1'b0, 38'h15_AAAA_5555};

    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_ir = 2'b00; cmd_data = '0;
    tdo_one = 1'b0;
    c1_valid = 1'b0; c1_rready = 1'b0; c1_ir = 2'b00; c1_data = '0;
    clr_mon();
    for (int i = 0; i < 3; i++) step();
    chk("ready_in_reset", cmd_ready, 0);
    chk("c1_ready_in_reset", c1_ready, 0);
    reset = 1'b0;
    #1;
    chk("reset_outs", {rsp_valid, vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_ready", cmd_ready, 1);

    // abort during SDR bit 17 (bit 17 of the data is 1)
    cmd_ir = 2'b11; cmd_data = 38'h12_3456_789A; cmd_valid = 1'b1;
    step(); n = 1;
    cmd_valid = 1'b0;
    while (n < 78) begin step(); n++; end
    chk("abort_in_sdr", vji_sdr, 1);
    chk("abort_tdi_bit17", vji_tdi, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("abort_outs", {rsp_valid, vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 0);
    chk("abort_rsp_data", rsp_data, 0);
    chk("abort_ready", cmd_ready, 1);
    bad = 0;
    for (int i = 0; i < 180; i++) begin
      step();
      if (rsp_valid || !cmd_ready) bad++;
    end
    chk("abort_no_rsp", bad, 0);

    for (int i = 0; i < 6; i++) run_cmd($sformatf("vec%0d", i), vecs[i]);

    // response stall with a competing command held
    tdo_one = 1'b0;
    cmd_ir = 2'b10; cmd_data = 38'h0F_0F0F_0F0F; cmd_valid = 1'b1;
    step(); n = 1;
    while (!rsp_valid && n < 400) begin step(); n++; end
    chk("stall_latency", n, 169);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!rsp_valid || rsp_data !== 38'h0F_0F0F_0F0F || cmd_ready || vji_uir) bad++;
    end
    chk("stall_stable", bad, 0);
    chk("stall_data", rsp_data, 38'h0F_0F0F_0F0F);
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("stall_release", rsp_valid, 0);

    // back-to-back issue with rsp_ready held high
    cmd_ir = 2'b00; cmd_data = 38'h2A_5555_AAAA; cmd_valid = 1'b1; rsp_ready = 1'b1;
    step(); n = 1;
    cmd_ir = 2'b11; cmd_data = 38'h05_A5A5_5A5A;
    bad = 0;
    while (!rsp_valid && n < 400) begin
      step(); n++;
      if (vji_ir_in !== 2'b00) bad++;
    end
    chk("b2b_latency", n, 169);
    chk("b2b_data1", rsp_data, 38'h2A_5555_AAAA);
    step();
    chk("b2b_idle_ready", cmd_ready, 1);
    chk("b2b_idle_rsp", rsp_valid, 0);
    chk("b2b_ir_hold", vji_ir_in, 2'b00);
    step();
    cmd_valid = 1'b0;
    chk("b2b_uir2", vji_uir, 1);
    chk("b2b_ir2", vji_ir_in, 2'b11);
    chk("b2b_ir_held_first", bad, 0);
    n = 1;
    while (!rsp_valid && n < 400) begin step(); n++; end
    chk("b2b_latency2", n, 169);
    chk("b2b_data2", rsp_data, 38'h05_A5A5_5A5A);
    step();
    rsp_ready = 1'b0;
    chk("b2b_done", rsp_valid, 0);

    // TCK_DIV=1 instance
    c1_ir = 2'b01; c1_data = 38'h2A_5555_AAAA; c1_valid = 1'b1;
    clr_mon();
    step(); n = 1;
    c1_valid = 1'b0;
    while (!c1_rvalid && n < 200) begin step(); n++; end
    chk("fast_latency", n, 85);
    chk("fast_data", c1_rdata, 38'h2A_5555_AAAA);
    chk("fast_toggle", c1_tog_err, 0);
    chk("fast_uir_cyc", c1cnt[0], 2);
    chk("fast_cdr_cyc", c1cnt[1], 2);
    chk("fast_sdr_cyc", c1cnt[2], 76);
    chk("fast_udr_cyc", c1cnt[3], 2);
    chk("fast_rti_cyc", c1cnt[4], 2);
    chk("fast_tck_resp", c1_tck, 0);
    c1_rready = 1'b1;
    step();
    c1_rready = 1'b0;
    chk("fast_release", c1_rvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reverb_template_nios2_debug_scan_master.md
REVERB_TEMPLATE_NIOS2_DEBUG_SCAN_MASTER -- requirements
Module: reverb_template_nios2_debug_scan_master

Interface
REQ-001 SHALL have parameter TCK_DIV, default 2, meaning clk cycles per vji_tck half-period (legal range 1..255).
REQ-002 SHALL have parameter DR_LEN, default 38, meaning data-register scan length in bits.
REQ-003 SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 cmd_valid  input  1  scan request present.
REQ-007 cmd_ready  output  1  request accepted when cmd_valid & cmd_ready.
REQ-008 cmd_ir  input  2  virtual IR value for this scan.
REQ-009 cmd_data  input  DR_LEN  data shifted out on vji_tdi, LSB first.
REQ-010 rsp_valid  output  1  captured scan data available.
REQ-011 rsp_ready  input  1  consumer accepts rsp_data.
REQ-012 rsp_data  output  DR_LEN  bits captured from vji_tdo; first captured bit in bit 0.
REQ-013 vji_tck  output  1  generated scan clock.
REQ-014 vji_tdi  output  1  serial data to debug slave.
REQ-015 vji_tdo  input  1  serial data from debug slave.
REQ-016 vji_ir_in  output  2  virtual IR presented to debug slave.
REQ-017 vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  output  1 each  virtual JTAG state strobes.

Function
REQ-018 FSM states SHALL be IDLE, UIR, CDR, SDR, UDR, RTI, RESP.
REQ-019 A "tck period" SHALL be 2*TCK_DIV clk cycles: vji_tck low for the first TCK_DIV, high for the second TCK_DIV; vji_tck SHALL be 0 in IDLE and RESP.
REQ-020 cmd_ready SHALL be 1 only in IDLE; on accept, cmd_ir and cmd_data SHALL be latched and FSM SHALL enter UIR next cycle.
REQ-021 UIR, CDR, UDR, RTI SHALL each last exactly one tck period, with the matching strobe high for that whole period and all other strobes low.
REQ-022 vji_ir_in SHALL take the latched cmd_ir at UIR entry and hold it until the next UIR or reset.
REQ-023 SDR SHALL last DR_LEN tck periods with vji_sdr high throughout; bit counter 0..DR_LEN-1.
REQ-024 In SDR, vji_tdi SHALL change only at the start of a low phase, driving latched data bit k in period k.
REQ-025 vji_tdo SHALL be sampled on the clk cycle where vji_tck goes 0->1 and shifted in as {tdo, sr[DR_LEN-1:1]}, so after DR_LEN samples rsp_data[0] is the first sample.
REQ-026 vji_tdi SHALL be 0 outside SDR.
REQ-027 After RTI, FSM SHALL enter RESP with rsp_valid=1 and rsp_data stable; RESP->IDLE on rsp_valid & rsp_ready.
REQ-028 Latency: with accept at cycle 0, rsp_valid SHALL first assert at cycle 1 + (DR_LEN+4)*2*TCK_DIV (169 for defaults).
REQ-029 cmd_valid while busy SHALL be ignored (no buffering); cmd_ready=0 back-pressures.
REQ-030 rsp_ready in any state other than RESP SHALL have no effect.
REQ-031 If rsp_ready is held 1, a new command SHALL be acceptable on the cycle after RESP exits (back-to-back issue, one IDLE cycle).
REQ-032 Half-period counter and bit counter SHALL wrap to 0 at end of each period/scan; no off-by-one extra period.

Reset
REQ-033 On reset=1 at any clk edge, FSM SHALL go to IDLE next cycle, aborting any scan without rsp_valid.
REQ-034 Reset values: cmd_ready=1 (after reset deasserts), rsp_valid=0, rsp_data=0, vji_tck=0, vji_tdi=0, vji_ir_in=0, all strobes 0.
REQ-035 While reset=1, cmd_ready SHALL be 0.

Verification
REQ-036 Defaults; cmd_ir=2'b01, cmd_data=38'h2A_5555_AAAA, tdo looped from tdi -> vji_ir_in=01 from UIR, rsp_valid at cycle 169, rsp_data=38'h2A_5555_AAAA.
REQ-037 tdo tied 1, cmd_data=0 -> vji_tdi 0 throughout, rsp_data=38'h3F_FFFF_FFFF, exactly 38 rising vji_tck edges while vji_sdr=1.
REQ-038 TCK_DIV=1 -> vji_tck toggles every clk in active states; rsp_valid at cycle 85; each strobe high exactly 2 clk.
REQ-039 rsp_ready held 0 for 20 cycles in RESP, cmd_valid high -> rsp_valid/rsp_data stable, cmd_ready=0, no new UIR until handshake.
REQ-040 Reset asserted 1 cycle mid-SDR (bit 17) -> next cycle all outputs at reset values, no rsp_valid; following command completes normally with correct data.
REQ-041 Two commands back-to-back with rsp_ready=1 (ir 00 then 11) -> second accepted one cycle after first RESP exit; vji_ir_in holds 00 until second UIR.
